// File: rtl/sprite_blit_ctrl_pkg.sv
// Shared definitions for the sprite bitmap-load controller.
//   state_e  : controller state encoding (IDLE / ISSUE / DRAIN)
//   cnt_bits : width of the transfer-length counter, one bit wider than the
//              bitmap address so that a full-bitmap transfer is representable.
package sprite_blit_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int unsigned cnt_bits(input int unsigned addr_bits);
    return addr_bits + 32'd1;
  endfunction

endpackage

// File: rtl/shift_register_vector.sv
// Fixed-depth delay line for a vector; every stage clears on reset.
//   clk, reset : system clock, synchronous active-high reset
//   i_d        : value entering the line
//   o_q        : value delayed by DEPTH cycles
module shift_register_vector #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/sprite_blit_ctrl.sv
// Sprite bitmap-load controller: copies a block of source-memory pixels (or,
// with SPRITE_BLIT_FILL_EN defined, a constant colour) into the sprite bitmap
// write port, stalling direct CPU bitmap writes while a transfer runs.
// Ports:
//   clk, reset                  : system clock, synchronous active-high reset
//   start, src_base, dst_base,
//   count                       : transfer request (count 0 = whole bitmap)
//   fill, fill_color            : fill-mode request (SPRITE_BLIT_FILL_EN only)
//   busy, done                  : transfer status / completion pulse
//   src_addr, src_oe, src_din   : source memory read port
//   cpu_address, cpu_din,
//   cpu_we, cpu_ready           : CPU bitmap write port with backpressure
//   bitmap_address, bitmap_din,
//   bitmap_we                   : to the sprite bitmap write port
// Build option: SPRITE_BLIT_FILL_EN adds the fill/fill_color ports.
module sprite_blit_ctrl
  import sprite_blit_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 13,
  parameter int unsigned BPP         = 8,
  parameter int unsigned SRC_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_base,
  input  logic [ADDR_BITS-1:0] dst_base,
  input  logic [ADDR_BITS:0]   count,
`ifdef SPRITE_BLIT_FILL_EN
  input  logic                 fill,
  input  logic [BPP-1:0]       fill_color,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          src_addr,
  output logic                 src_oe,
  input  logic [BPP-1:0]       src_din,
  input  logic [31:0]          cpu_address,
  input  logic [BPP-1:0]       cpu_din,
  input  logic                 cpu_we,
  output logic                 cpu_ready,
  output logic [31:0]          bitmap_address,
  output logic [BPP-1:0]       bitmap_din,
  output logic                 bitmap_we
);

  localparam int unsigned CNT_W = cnt_bits(ADDR_BITS);
  localparam int unsigned DL_W  = ADDR_BITS + 1;
  localparam int unsigned INF_W = $clog2(SRC_LATENCY + 2);

  state_e               r_state;
  state_e               w_state_next;
  logic [31:0]          r_src_addr;
  logic [ADDR_BITS-1:0] r_dst;
  logic [CNT_W-1:0]     r_remaining;
  logic [CNT_W-1:0]     w_eff_cnt;
  logic                 r_fill;
  logic [BPP-1:0]       r_fill_color;
  logic                 w_fill_in;
  logic [BPP-1:0]       w_color_in;
  logic                 r_src_oe;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_cpu_ready;
  logic [INF_W-1:0]     r_inflight;
  logic                 r_bitmap_we;
  logic [31:0]          r_bitmap_address;
  logic [BPP-1:0]       r_bitmap_din;
  logic                 w_load;
  logic                 w_push;
  logic                 w_done_next;
  logic                 w_busy_next;
  logic                 w_src_oe_next;
  logic                 w_cpu_acc;
  logic [DL_W-1:0]      w_dl_d;
  logic [DL_W-1:0]      w_dl_q;
  logic                 w_dl_valid;
  logic [ADDR_BITS-1:0] w_dl_dst;

`ifdef SPRITE_BLIT_FILL_EN
  assign w_fill_in  = fill;
  assign w_color_in = fill_color;
`else
  assign w_fill_in  = 1'b0;
  assign w_color_in = '0;
`endif

  // A zero count requests the whole bitmap.
  assign w_eff_cnt = (count == '0) ? (CNT_W'(1) << ADDR_BITS) : count;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and control decode
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_push       = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // busy is still high during the done cycle; a start then is ignored
        if (start && !r_busy) begin
          w_load       = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_push = 1'b1;
        if (r_remaining == CNT_W'(1)) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_inflight == '0) begin
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_cpu_acc     = (r_state == ST_IDLE) && !r_busy && cpu_we;
    w_busy_next   = (w_state_next != ST_IDLE) || w_done_next;
    w_src_oe_next = (w_state_next == ST_ISSUE) && !(w_load ? w_fill_in : r_fill);
  end

  // Delay line carries {valid, dst} alongside the source read latency.
  assign w_dl_d     = {w_push, r_dst};
  assign w_dl_valid = w_dl_q[DL_W-1];
  assign w_dl_dst   = w_dl_q[ADDR_BITS-1:0];

  shift_register_vector #(
    .WIDTH (DL_W),
    .DEPTH (SRC_LATENCY)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_dl_d),
    .o_q   (w_dl_q)
  );

  // Datapath, status and bitmap port registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src_addr       <= '0;
      r_dst            <= '0;
      r_remaining      <= '0;
      r_fill           <= 1'b0;
      r_fill_color     <= '0;
      r_src_oe         <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_cpu_ready      <= 1'b1;
      r_inflight       <= '0;
      r_bitmap_we      <= 1'b0;
      r_bitmap_address <= '0;
      r_bitmap_din     <= '0;
    end else begin
      if (w_load) begin
        r_src_addr   <= src_base;
        r_dst        <= dst_base;
        r_remaining  <= w_eff_cnt;
        r_fill       <= w_fill_in;
        r_fill_color <= w_color_in;
      end else if (w_push) begin
        r_src_addr  <= r_src_addr + 32'd1;
        r_dst       <= r_dst + ADDR_BITS'(1);
        r_remaining <= r_remaining - CNT_W'(1);
      end
      r_src_oe    <= w_src_oe_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_cpu_ready <= !w_busy_next;
      // Entries in the delay line that have not yet reached the bitmap port
      r_inflight  <= r_inflight + INF_W'(w_push) - INF_W'(w_dl_valid);
      // Transfer writes and CPU writes never overlap: CPU is only accepted when idle
      if (w_dl_valid) begin
        r_bitmap_we      <= 1'b1;
        r_bitmap_address <= 32'(w_dl_dst);
        r_bitmap_din     <= r_fill ? r_fill_color : src_din;
      end else if (w_cpu_acc) begin
        r_bitmap_we      <= 1'b1;
        r_bitmap_address <= cpu_address;
        r_bitmap_din     <= cpu_din;
      end else begin
        r_bitmap_we <= 1'b0;
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign src_addr       = r_src_addr;
  assign src_oe         = r_src_oe;
  assign cpu_ready      = r_cpu_ready;
  assign bitmap_we      = r_bitmap_we;
  assign bitmap_address = r_bitmap_address;
  assign bitmap_din     = r_bitmap_din;

endmodule

// File: doc/sprite_blit_ctrl.md
# sprite_blit_ctrl

Bitmap-load controller for the sprite engine. On a start request it copies a block of pixels from a source memory, or fills a region with a constant colour, into the sprite bitmap write port. While a copy runs it holds off the CPU's direct bitmap writes with backpressure. It runs in the system `clk` domain next to the sprite's bitmap write port; the sprite's own clock-domain crossing (dual-clock RAM) is unchanged.

## Interface

Parameters:
- `ADDR_BITS`, 13: bitmap address width (sprite width bits + height bits).
- `BPP`, 8: bits per pixel.
- `SRC_LATENCY`, 2: source-memory read latency in cycles, from `src_oe` to valid `src_din`; must be ≥1.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `src_base` input 32: first source word address.
- `dst_base` input ADDR_BITS: first bitmap address.
- `count` input ADDR_BITS+1: pixels to transfer; 0 means 1<<ADDR_BITS.
- `fill` input 1: fill mode, sampled with `start`; exists only with the macro.
- `fill_color` input BPP: fill value, sampled with `start`; exists only with the macro.
- `busy` output 1: a transfer is in progress.
- `done` output 1: one-cycle pulse on completion.
- `src_addr` output 32: source read address.
- `src_oe` output 1: source read strobe.
- `src_din` input BPP: source read data.
- `cpu_address` input 32: CPU bitmap write address.
- `cpu_din` input BPP: CPU write data.
- `cpu_we` input 1: CPU write request.
- `cpu_ready` output 1: CPU write accepted this cycle.
- `bitmap_address` output 32: to sprite `bitmap_address`.
- `bitmap_din` output BPP: to sprite `bitmap_din`.
- `bitmap_we` output 1: to sprite `bitmap_we`.

## Operation

- States: IDLE, ISSUE, DRAIN.
  - IDLE → ISSUE on `start`. At that cycle the block latches `src_base`, `dst_base`, the effective count, `fill` and `fill_color`.
  - ISSUE issues one read per cycle. It moves to DRAIN in the cycle after the last read issues.
  - DRAIN waits until the write pipeline is empty, then goes to IDLE and pulses `done`.
- Read pipeline: each `src_oe` pushes {valid, dst address} into an SRC_LATENCY-deep delay line. When an entry emerges, the block registers `bitmap_we`=1, `bitmap_address`={zero-extend, dst}, `bitmap_din`=`src_din`.
- Address arithmetic:
  - Source address increments by 1 per read, 32-bit with natural wrap.
  - Destination address is ADDR_BITS wide and wraps modulo 1<<ADDR_BITS.
- Arbitration:
  - `cpu_ready` = !busy.
  - In IDLE a CPU write passes through registered, one cycle later, onto the bitmap port.
  - In ISSUE or DRAIN CPU writes are stalled (`cpu_ready`=0). The CPU must hold its request until accepted.
  - A `start` and a `cpu_we` in the same IDLE cycle: the CPU write is accepted and written, and the transfer starts. The CPU write reaches the bitmap port before any transfer write.
- `start` while `busy` is ignored and no error is raised.
- `busy`=1 from the cycle after `start` through the cycle `done` is high.

## Timing

- `start` is high in cycle 0. Reads issue in cycles 1..N (`src_oe` and `src_addr` registered).
- Write k is at cycle k+SRC_LATENCY+1. The last write is at N+SRC_LATENCY+1.
- `done` is at N+SRC_LATENCY+2. `busy` is 0 from N+SRC_LATENCY+3.
- Reset values: `busy`=0, `done`=0, `src_oe`=0, `src_addr`=0, `bitmap_we`=0, `bitmap_address`=0, `bitmap_din`=0, `cpu_ready`=1 in the cycle after reset.
- Reset mid-transfer:
  - The state returns to IDLE, the delay line is cleared, and no further writes occur.
  - `done` is not pulsed.
  - Writes already performed remain in the bitmap.

## Configuration

- `SPRITE_BLIT_FILL_EN`:
  - Defined: the `fill` and `fill_color` ports exist. With `fill`=1, each ISSUE cycle produces a write of `fill_color` with no `src_oe`. Timing is otherwise identical, including the SRC_LATENCY delay, so `done` timing is mode-independent.
  - Undefined: the ports are absent and copy mode only.

## Structure

- Shared package: the state encoding (IDLE/ISSUE/DRAIN) and a count-width helper constant, ADDR_BITS+1.
- Sub-module: the existing `shift_register_vector`, used as the valid+address delay line (WIDTH=ADDR_BITS+1, DEPTH=SRC_LATENCY).

## Test plan

- Copy, N=4, src_base=0x100, dst_base=0, SRC_LATENCY=2 → writes at cycles 4..7 to bitmap addresses 0..3 with the source words at 0x100..0x103; `done` at cycle 8.
- dst_base=0x1FFE, N=4, ADDR_BITS=13 → writes to 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- `count`=0 → 8192 writes, then `done`; `busy` continuous for the whole transfer.
- `cpu_we` held during a transfer → `cpu_ready`=0 until the cycle after `done`; then exactly one CPU write appears on the bitmap port.
- Reset asserted at cycle 3 of an N=8 copy → no `bitmap_we` after reset and no `done`; outputs show reset values.
- With `SPRITE_BLIT_FILL_EN`, `fill`=1, `fill_color`=0x5A, N=3 → three writes of 0x5A; `src_oe` never asserted; `done` at cycle 3+2+2=7.
